// File: rtl/spi_pkg.sv
// Shared SPI constants and the peripheral state encoding.
package spi_pkg;
   localparam int ADC_DATA_WIDTH      = 17;
   localparam int ADC_DATA_CLK_PERIOD = 50;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } spi_per_state_t;
endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit; DEPTH must be at least 2.
module synchronizer #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_in,
   output logic q_out
);
   logic [DEPTH-1:0] stages_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stages_q <= {DEPTH{RESET_VAL}};
      end else begin
         stages_q <= {stages_q[DEPTH-2:0], d_in};
      end
   end

   assign q_out = stages_q[DEPTH-1];
endmodule

// File: rtl/spi_per.sv
// SPI mode-0 peripheral: receives DATA_WIDTH bits MSB first while shifting out
// the word captured at the chip-select falling edge.
module spi_per
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  chip_clk_in,
   input  logic                  chip_data_in,
   input  logic                  chip_sel_in,
   output logic                  chip_data_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid_out,
   output logic                  busy_out,
   output spi_per_state_t        state_out
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

   logic clk_s, dat_s, sel_s;
   logic clk_prev_q, sel_prev_q;
   logic clk_rise, clk_fall, sel_rise, sel_fall;
   logic [SYNC_STAGES:0]  settle_q;
   logic                  armed_q;
   spi_per_state_t        state_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] rx_q, data_q;
   logic [DATA_WIDTH-2:0] tx_q;
   logic                  cdo_q, valid_q, busy_q;

   synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(chip_clk_in), .q_out(clk_s));
   synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dat (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(chip_data_in), .q_out(dat_s));
   synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(chip_sel_in), .q_out(sel_s));

   assign clk_rise = clk_s & ~clk_prev_q;
   assign clk_fall = ~clk_s & clk_prev_q;
   assign sel_rise = sel_s & ~sel_prev_q;
   assign sel_fall = ~sel_s & sel_prev_q;

   // A select already low when reset releases must not start a frame: arm only
   // after the synchronizers have flushed and select has been seen high.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         clk_prev_q <= 1'b0;
         sel_prev_q <= 1'b1;
         settle_q   <= '0;
         armed_q    <= 1'b0;
      end else begin
         clk_prev_q <= clk_s;
         sel_prev_q <= sel_s;
         settle_q   <= {settle_q[SYNC_STAGES-1:0], 1'b1};
         armed_q    <= armed_q | (settle_q[SYNC_STAGES] & sel_s & sel_prev_q);
      end
   end

   // data_valid_out is a one-cycle strobe; data_out holds that word until the next strobe.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         data_q  <= '0;
         cdo_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cdo_q  <= 1'b0;
               busy_q <= 1'b0;
               if (sel_fall && armed_q) begin
                  state_q <= ST_ACTIVE;
                  tx_q    <= data_in[DATA_WIDTH-2:0];
                  cdo_q   <= data_in[DATA_WIDTH-1];
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (sel_rise) begin
                  state_q <= ST_IDLE;
                  cdo_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_FULL) begin
                  state_q <= ST_DONE;
                  data_q  <= rx_q;
                  valid_q <= 1'b1;
                  cdo_q   <= 1'b0;
               end else begin
                  if (clk_rise) begin
                     rx_q  <= {rx_q[DATA_WIDTH-2:0], dat_s};
                     cnt_q <= cnt_q + CW'(1);
                  end
                  if (clk_fall) begin
                     tx_q  <= {tx_q[DATA_WIDTH-3:0], 1'b0};
                     cdo_q <= tx_q[DATA_WIDTH-2];
                  end
               end
            end
            ST_DONE: begin
               cdo_q <= 1'b0;
               if (sel_rise) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cdo_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign chip_data_out  = cdo_q;
   assign data_out       = data_q;
   assign data_valid_out = valid_q;
   assign busy_out       = busy_q;
   assign state_out      = state_q;
endmodule
